// File: rtl/regfile_alu_datapath.sv
`default_nettype none
// regfile_alu_datapath: 16x16 register file feeding a single-cycle ALU with multi-hot
// write-back, a 5-bit {L,C,F,Z,N} flag register and same-cycle flag bypass.
module regfile_alu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] wEnable,
  input  logic [15:0] Imm_in,
  input  logic [7:0]  opcode,
  input  logic [3:0]  Rdest_sel,
  input  logic [3:0]  Rsrc_sel,
  input  logic        Imm_sel,
  output logic [4:0]  Flags_out,
  output logic [15:0] Data_out,
  output logic [15:0] ALU_out
);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDUI = 8'h60;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_CMPI = 8'hB0;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MOVI = 8'hD0;

  // Flag bit positions within {L, C, F, Z, N}
  localparam int FL_L = 4;
  localparam int FL_C = 3;
  localparam int FL_F = 2;
  localparam int FL_Z = 1;
  localparam int FL_N = 0;

  logic [15:0] regs [16];
  logic [4:0]  flag_reg;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] alu_res;
  logic [16:0] sum;
  logic [16:0] diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic        write_op;
  logic        flag_op;
  logic [4:0]  flags_next;

  assign op_a = regs[Rdest_sel];
  assign op_b = Imm_sel ? regs[Rsrc_sel] : Imm_in;

  // Bit 16 of diff is the unsigned borrow (A < B).
  assign sum     = {1'b0, op_a} + {1'b0, op_b};
  assign diff    = {1'b0, op_a} - {1'b0, op_b};
  assign add_ovf = (op_a[15] == op_b[15]) & (sum[15] != op_a[15]);
  assign sub_ovf = (op_a[15] != op_b[15]) & (diff[15] != op_a[15]);

  always_comb begin
    alu_res    = '0;
    write_op   = 1'b0;
    flag_op    = 1'b0;
    flags_next = flag_reg;
    case (opcode)
      OP_ADDU, OP_ADDUI: begin
        alu_res          = sum[15:0];
        write_op         = 1'b1;
        flag_op          = 1'b1;
        flags_next[FL_C] = sum[16];
        flags_next[FL_F] = add_ovf;
      end
      OP_SUB: begin
        alu_res          = diff[15:0];
        write_op         = 1'b1;
        flag_op          = 1'b1;
        flags_next[FL_C] = diff[16];
        flags_next[FL_F] = sub_ovf;
      end
      OP_AND: begin
        alu_res  = op_a & op_b;
        write_op = 1'b1;
      end
      OP_OR: begin
        alu_res  = op_a | op_b;
        write_op = 1'b1;
      end
      OP_XOR: begin
        alu_res  = op_a ^ op_b;
        write_op = 1'b1;
      end
      OP_MOV, OP_MOVI: begin
        alu_res  = op_b;
        write_op = 1'b1;
      end
      OP_CMP, OP_CMPI: begin
        // Signed less-than is the sign of the difference corrected for overflow.
        alu_res          = diff[15:0];
        flag_op          = 1'b1;
        flags_next[FL_L] = diff[16];
        flags_next[FL_Z] = (op_a == op_b);
        flags_next[FL_N] = diff[15] ^ sub_ovf;
      end
      OP_NOP:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) regs[k] <= '0;
      flag_reg <= '0;
    end else begin
      if (write_op) begin
        for (int k = 0; k < 16; k++) begin
          if (wEnable[k]) regs[k] <= alu_res;
        end
      end
      if (flag_op) flag_reg <= flags_next;
    end
  end

  assign ALU_out   = alu_res;
  assign Data_out  = regs[5];
  // Reset gating keeps a live compare from leaking flags while reset is held.
  assign Flags_out = reset ? flags_next : 5'b00000;

endmodule
`default_nettype wire

// File: tb/tb_regfile_alu_datapath.sv
`default_nettype none
// tb_regfile_alu_datapath: directed and randomized stimulus checked against an
// arithmetic reference model of the register file, ALU and flags.
module tb_regfile_alu_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wEnable;
  logic [15:0] Imm_in;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_sel;
  logic [3:0]  Rsrc_sel;
  logic        Imm_sel;
  logic [4:0]  Flags_out;
  logic [15:0] Data_out;
  logic [15:0] ALU_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [16];
  logic [4:0]  m_flags;
  logic [4:0]  fs;

  always #5 clk = ~clk;

  regfile_alu_datapath dut (
    .clk(clk), .reset(reset), .wEnable(wEnable), .Imm_in(Imm_in), .opcode(opcode),
    .Rdest_sel(Rdest_sel), .Rsrc_sel(Rsrc_sel), .Imm_sel(Imm_sel),
    .Flags_out(Flags_out), .Data_out(Data_out), .ALU_out(ALU_out)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference semantics in plain integer arithmetic; flags are {L,C,F,Z,N}.
  function automatic void model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [4:0] fin, output logic [15:0] res,
                                output logic [4:0] fo, output logic wr);
    int u;
    int s;
    fo = fin; res = '0; wr = 1'b0;
    case (op)
      8'h06, 8'h60: begin
        u = int'(a) + int'(b);
        s = int'($signed(a)) + int'($signed(b));
        res = u[15:0]; wr = 1'b1;
        fo[3] = (u > 65535);
        fo[2] = (s > 32767) || (s < -32768);
      end
      8'h09: begin
        u = int'(a) - int'(b);
        s = int'($signed(a)) - int'($signed(b));
        res = u[15:0]; wr = 1'b1;
        fo[3] = (u < 0);
        fo[2] = (s > 32767) || (s < -32768);
      end
      8'h01: begin res = a & b; wr = 1'b1; end
      8'h02: begin res = a | b; wr = 1'b1; end
      8'h03: begin res = a ^ b; wr = 1'b1; end
      8'h0D, 8'hD0: begin res = b; wr = 1'b1; end
      8'h0B, 8'hB0: begin
        u = int'(a) - int'(b);
        res = u[15:0];
        fo[4] = (a < b);
        fo[1] = (a == b);
        fo[0] = ($signed(a) < $signed(b));
      end
      default: res = '0;
    endcase
  endfunction

  task automatic op(input logic [7:0] o, input logic [3:0] rd, input logic [3:0] rs,
                    input logic isel, input logic [15:0] imm, input logic [15:0] we,
                    output logic [4:0] seen);
    logic [15:0] a, b, res;
    logic [4:0]  fo;
    logic        wr;
    @(negedge clk);
    opcode = o; Rdest_sel = rd; Rsrc_sel = rs; Imm_sel = isel; Imm_in = imm; wEnable = we;
    #1;
    a = m_regs[rd];
    b = isel ? m_regs[rs] : imm;
    model(o, a, b, m_flags, res, fo, wr);
    seen = Flags_out;
    check("alu_out", ALU_out, res);
    check("flags_out", 16'(Flags_out), 16'(fo));
    check("data_out", Data_out, m_regs[5]);
    @(posedge clk);
    if (wr) begin
      for (int k = 0; k < 16; k++) if (we[k]) m_regs[k] = res;
    end
    m_flags = fo;
  endtask

  // Reads a register through a non-writing MOV and compares to a fixed value.
  task automatic expect_reg(input string tag, input logic [3:0] k, input logic [15:0] v);
    @(negedge clk);
    opcode = 8'h0D; Rsrc_sel = k; Imm_sel = 1'b1; wEnable = '0; Rdest_sel = '0; Imm_in = '0;
    #1;
    check(tag, ALU_out, v);
    @(posedge clk);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_regs[k] = '0;
    m_flags = '0;
  endtask

  task automatic fib_init();
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd0,  16'h0002, fs);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd1,  16'h0004, fs);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd0,  16'h0008, fs);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd10, 16'h0010, fs);
  endtask

  task automatic fib_body();
    op(8'h06, 4'd1, 4'd2, 1'b1, 16'd0, 16'h0040, fs);
    op(8'h0D, 4'd0, 4'd2, 1'b1, 16'd0, 16'h0002, fs);
    op(8'h0D, 4'd0, 4'd6, 1'b1, 16'd0, 16'h0004, fs);
    op(8'h60, 4'd3, 4'd0, 1'b0, 16'd1, 16'h0008, fs);
  endtask

  logic [7:0] op_tab [12];
  int iters;

  initial begin
    op_tab = '{8'h00, 8'h06, 8'h60, 8'h09, 8'h01, 8'h02, 8'h03, 8'h0B, 8'hB0, 8'h0D, 8'hD0, 8'h00};
    reset = 1'b0; wEnable = '0; Imm_in = '0; opcode = '0; Rdest_sel = '0; Rsrc_sel = '0; Imm_sel = 1'b0;
    model_reset();
    #2;
    check("reset_data_out", Data_out, 16'h0000);
    check("reset_flags_out", 16'(Flags_out), 16'h0000);

    // Writes while reset is held must be ignored.
    opcode = 8'hD0; Imm_in = 16'hFFFF; wEnable = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check("reset_write_ignored", Data_out, 16'h0000);
    @(negedge clk);
    reset = 1'b1; opcode = 8'h00; wEnable = '0;

    op(8'h60, 4'd1, 4'd0, 1'b0, 16'd1, 16'h0002, fs);
    check("addui_flags", 16'(fs), 16'h0000);
    expect_reg("addui_r1", 4'd1, 16'h0001);

    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd0,  16'h0008, fs);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd10, 16'h0010, fs);
    op(8'h0B, 4'd3, 4'd4, 1'b1, 16'd0, 16'h0000, fs);
    check("cmp_lt_L", 16'(fs[4]), 16'h0001);
    check("cmp_lt_flags", 16'(fs), 16'h0011);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'd10, 16'h0008, fs);
    op(8'h0B, 4'd3, 4'd4, 1'b1, 16'd0, 16'h0000, fs);
    check("cmp_eq_L", 16'(fs[4]), 16'h0000);
    check("cmp_eq_Z", 16'(fs[1]), 16'h0001);

    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'hFFFF, 16'h0001, fs);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'h0001, 16'h0002, fs);
    op(8'h06, 4'd0, 4'd1, 1'b1, 16'd0, 16'h0004, fs);
    check("addu_carry_flags", 16'(fs), 16'h000A);
    expect_reg("addu_r2", 4'd2, 16'h0000);

    op(8'h0B, 4'd0, 4'd1, 1'b1, 16'd0, 16'hFFFF, fs);
    op(8'h00, 4'd0, 4'd1, 1'b0, 16'h5555, 16'hFFFF, fs);
    expect_reg("nowrite_r0", 4'd0, 16'hFFFF);
    expect_reg("nowrite_r1", 4'd1, 16'h0001);
    expect_reg("nowrite_r4", 4'd4, 16'd10);
    op(8'hD0, 4'd0, 4'd0, 1'b0, 16'h1234, 16'h0021, fs);
    #1;
    check("movi_data_out", Data_out, 16'h1234);
    expect_reg("movi_r0", 4'd0, 16'h1234);
    expect_reg("movi_r5", 4'd5, 16'h1234);

    fib_init();
    iters = 0;
    for (int n = 0; n < 20; n++) begin
      op(8'h0B, 4'd3, 4'd4, 1'b1, 16'd0, 16'h0000, fs);
      if (!m_flags[4]) break;
      fib_body();
      iters++;
    end
    op(8'h0D, 4'd0, 4'd2, 1'b1, 16'd0, 16'h0020, fs);
    #1;
    check("fib_iters", 16'(iters), 16'd10);
    check("fib_data_out", Data_out, 16'h0059);
    expect_reg("fib_r3", 4'd3, 16'd10);

    fib_init();
    op(8'h0D, 4'd0, 4'd4, 1'b1, 16'd0, 16'h0020, fs);
    for (int n = 0; n < 4; n++) begin
      op(8'h0B, 4'd3, 4'd4, 1'b1, 16'd0, 16'h0000, fs);
      fib_body();
    end
    @(negedge clk);
    opcode = 8'h0B; Rdest_sel = 4'd3; Rsrc_sel = 4'd4; Imm_sel = 1'b1; wEnable = '0;
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_data_out", Data_out, 16'h0000);
    check("async_rst_flags_out", 16'(Flags_out), 16'h0000);
    model_reset();
    opcode = 8'hD0; Imm_in = 16'hBEEF; Imm_sel = 1'b0; wEnable = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; opcode = 8'h00; wEnable = '0;
    for (int k = 0; k < 16; k++) expect_reg("post_rst_reg", 4'(k), 16'h0000);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] o;
      o = (n % 13 == 12) ? 8'($urandom) : op_tab[$urandom_range(0, 11)];
      op(o, 4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), fs);
    end
    for (int k = 0; k < 16; k++) expect_reg("final_reg", 4'(k), m_regs[k]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_alu_datapath.md
REGFILE_ALU_DATAPATH -- requirements
Module: regfile_alu_datapath

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 wEnable  input  16  register write enables; bit k selects register rk; multi-hot permitted.
REQ-004 Imm_in  input  16  immediate operand.
REQ-005 opcode  input  8  ALU operation select.
REQ-006 Rdest_sel  input  4  register read as operand A.
REQ-007 Rsrc_sel  input  4  register read as operand B when Imm_sel=1.
REQ-008 Imm_sel  input  1  operand B select: 1 = reg[Rsrc_sel], 0 = Imm_in.
REQ-009 Flags_out  output  5  {L, C, F, Z, N}; bit4 = L.
REQ-010 Data_out  output  16  current contents of r5, registered.
REQ-011 ALU_out  output  16  combinational ALU result of the current cycle.

Function
REQ-012 Register file SHALL hold 16 x 16-bit registers r0..r15; reads combinational from current state.
REQ-013 Operand A SHALL be reg[Rdest_sel]; operand B SHALL be reg[Rsrc_sel] if Imm_sel=1, else Imm_in.
REQ-014 Supported opcodes SHALL be: NOP 0x00, ADDU 0x06, ADDUI 0x60, SUB 0x09, AND 0x01, OR 0x02, XOR 0x03, CMP 0x0B, CMPI 0xB0, MOV 0x0D, MOVI 0xD0.
REQ-015 ADDU/ADDUI SHALL compute A+B modulo 2^16; SUB SHALL compute A-B modulo 2^16; AND/OR/XOR SHALL be bitwise; MOV/MOVI SHALL pass B; CMP/CMPI SHALL compute A-B without writing.
REQ-016 Write-producing opcodes (ADDU, ADDUI, SUB, AND, OR, XOR, MOV, MOVI) SHALL, on the rising edge, write ALU_out into every rk with wEnable[k]=1.
REQ-017 Write address SHALL come from wEnable only; Rdest_sel SHALL never select the write target.
REQ-018 NOP, CMP, CMPI and any undefined opcode SHALL write no register regardless of wEnable; undefined opcodes SHALL produce ALU_out = 0x0000.
REQ-019 ADDU/ADDUI/SUB SHALL update C (unsigned carry-out; for SUB, borrow) and F (signed overflow); L, Z and N SHALL be held.
REQ-020 CMP/CMPI SHALL update L = (A < B) unsigned, Z = (A == B), N = (A < B) signed; C and F SHALL be held.
REQ-021 AND, OR, XOR, MOV, MOVI, NOP and undefined opcodes SHALL leave all flags unchanged.
REQ-022 A 5-bit flag register SHALL capture updated flags on the rising edge of each flag-setting cycle.
REQ-023 Flags_out SHALL be bypassed: during a flag-setting cycle it SHALL show the newly computed flags combined with the held flag-register bits; otherwise it SHALL show the flag register.
REQ-024 Latency: a register write is visible on reads and Data_out one cycle after the issuing cycle; compare flags are visible on Flags_out in the same cycle.
REQ-025 Back-to-back dependent operations SHALL read the value written by the previous cycle's edge, with no stall.
REQ-026 Data_out SHALL update only when wEnable[5]=1 together with a write-producing opcode.

Reset
REQ-027 While reset=0, r0..r15 and the flag register SHALL be 0 asynchronously, without a clock edge.
REQ-028 While reset=0, Data_out SHALL be 0x0000 and Flags_out SHALL be 5'b00000.
REQ-029 While reset=0, write inputs SHALL be ignored.
REQ-030 Normal operation SHALL resume on the first rising edge after reset returns to 1.
REQ-031 Reset asserted mid-sequence SHALL discard all register and flag state.

Verification
REQ-032 After reset, drive ADDUI Rdest=1, Imm_in=1, Imm_sel=0, wEnable=0x0002 -> r1=0x0001 next cycle; Flags_out=0.
REQ-033 Set r3=0 and r4=10, then drive CMP Rdest=3, Rsrc=4, Imm_sel=1 -> Flags_out[4]=1 in the same cycle; with r3=10 -> Flags_out[4]=0 and Z=1.
REQ-034 Set r0=0xFFFF and r1=0x0001, then drive ADDU Rdest=0, Rsrc=1, wEnable=0x0004 -> r2=0x0000, C=1, F=0; L, Z and N unchanged.
REQ-035 Drive CMP and NOP with wEnable=0xFFFF -> no register changes; MOVI Imm_in=0x1234 with wEnable=0x0021 -> r0=r5=0x1234 and Data_out=0x1234.
REQ-036 Run the 10-iteration Fibonacci control sequence (init b=1, N=10; compare i<N; add; move; increment; write out) -> loop exits with r3=10 and Data_out=0x0059 (89).
REQ-037 Drop reset to 0 asynchronously mid-loop -> Data_out=0 and Flags_out=0 immediately; all registers read 0 after release.
